smart_toilet_seq_ctrl: RTL and testbench

Timed pump/valve sequencer for the smart-toilet mixing chip.
- Drives the three inlet pumps (soln1, soln2, soln3) and the outlet valve.
- soln2 and soln3 are primed first because their serpentine paths are longer; soln1 is dosed last. The sequence then dwells for mixing, opens the outlet for sampling, and flushes.
- Sits between the host/config register block and the pneumatic pump/valve drivers.

---
 rtl/smart_toilet_ctrl_pkg.sv | 45 ++++
 rtl/st_phase_timer.sv | 39 +++
 rtl/smart_toilet_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_smart_toilet_seq_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/smart_toilet_ctrl_pkg.sv
// rtl/smart_toilet_ctrl_pkg.sv - state codes and per-state pump/valve patterns for the toilet sequencer
package smart_toilet_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME2 = 3'd1,
        ST_PRIME3 = 3'd2,
        ST_DOSE1  = 3'd3,
        ST_MIX    = 3'd4,
        ST_SAMPLE = 3'd5,
        ST_FLUSH  = 3'd6,
        ST_FIN    = 3'd7
    } st_state_e;

    localparam int PUMP_SOLN1 = 0;
    localparam int PUMP_SOLN2 = 1;
    localparam int PUMP_SOLN3 = 2;

    localparam logic [2:0] PUMP_NONE   = 3'b000;
    localparam logic [2:0] PUMP_PRIME2 = 3'(1 << PUMP_SOLN2);
    localparam logic [2:0] PUMP_PRIME3 = 3'(1 << PUMP_SOLN3);
    localparam logic [2:0] PUMP_DOSE1  = 3'(1 << PUMP_SOLN1);
    localparam logic [2:0] PUMP_FLUSH  = 3'b111;

    localparam logic VALVE_CLOSED = 1'b0;
    localparam logic VALVE_OPEN   = 1'b1;

    function automatic logic [2:0] state_pump_en(input st_state_e s);
        case (s)
            ST_PRIME2: return PUMP_PRIME2;
            ST_PRIME3: return PUMP_PRIME3;
            ST_DOSE1:  return PUMP_DOSE1;
            ST_FLUSH:  return PUMP_FLUSH;
            default:   return PUMP_NONE;
        endcase
    endfunction

    function automatic logic state_valve_open(input st_state_e s);
        case (s)
            ST_SAMPLE, ST_FLUSH: return VALVE_OPEN;
            default:             return VALVE_CLOSED;
        endcase
    endfunction

endpackage

// File: rtl/st_phase_timer.sv
// rtl/st_phase_timer.sv - loadable saturating down-counter timing one sequencer phase
// Ports: clk, rst_n (sync, active-low); load/load_val reload the counter;
//        value is the current count; expired is high while the count is zero.
module st_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // Holds at zero rather than wrapping; the FSM leaves the phase on zero.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign expired = (value_q == '0);

endmodule

// File: rtl/smart_toilet_seq_ctrl.sv
// rtl/smart_toilet_seq_ctrl.sv - timed pump/valve sequencer: prime2, prime3, dose1, mix, sample, flush
// Ports: clk, rst_n (sync, active-low); start/abort run control; t_* phase durations
//        in cycles (latched at start); pump_en/valve_out_open/sample_valid drive the
//        fluidics; busy, done/aborted pulses and phase report status. All outputs registered.
module smart_toilet_seq_ctrl
    import smart_toilet_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] t_prime2,
    input  logic [CNT_W-1:0] t_prime3,
    input  logic [CNT_W-1:0] t_dose1,
    input  logic [CNT_W-1:0] t_mix,
    input  logic [CNT_W-1:0] t_sample,
    input  logic [CNT_W-1:0] t_flush,
    output logic [2:0]       pump_en,
    output logic             valve_out_open,
    output logic             sample_valid,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       phase
);

    // Index 0..5 = PRIME2..FLUSH, i.e. state code minus one.
    localparam int N_PH   = 6;
    localparam int IX_FLS = 5;

    st_state_e              state_q, state_d;
    logic                   abort_flag_q, abort_flag_d;
    logic [N_PH-1:0][CNT_W-1:0] dur_q, dur_d, dur_in, dur_sel;
    logic [N_PH-1:0]        nz;

    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_load_val;
    logic [CNT_W-1:0]       tmr_value;
    logic                   tmr_expired;

    logic [2:0]             pump_en_q, pump_en_d;
    logic                   valve_q, valve_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;

    // First phase at or after from_idx with a nonzero duration; FIN if none remain.
    function automatic st_state_e next_phase(input logic [2:0] from_idx, input logic [N_PH-1:0] nzv);
        st_state_e r;
        r = ST_FIN;
        for (int i = N_PH - 1; i >= 0; i--) begin
            if (i >= int'(from_idx) && nzv[i]) begin
                r = st_state_e'(3'(i + 1));
            end
        end
        return r;
    endfunction

    st_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value),
        .expired  (tmr_expired)
    );

    // In IDLE the live inputs are used so the first phase is chosen on the accept edge.
    always_comb begin
        dur_in  = {t_flush, t_sample, t_mix, t_dose1, t_prime3, t_prime2};
        dur_sel = (state_q == ST_IDLE) ? dur_in : dur_q;
        dur_d   = (state_q == ST_IDLE && start) ? dur_in : dur_q;
        for (int i = 0; i < N_PH; i++) begin
            nz[i] = (dur_sel[i] != '0);
        end
    end

    always_comb begin
        state_d      = state_q;
        abort_flag_d = abort_flag_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                abort_flag_d = 1'b0;
                if (start) begin
                    state_d = next_phase(3'd0, nz);
                end
            end
            ST_PRIME2, ST_PRIME3, ST_DOSE1, ST_MIX, ST_SAMPLE: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                    state_d      = nz[IX_FLS] ? ST_FLUSH : ST_FIN;
                end else if (tmr_expired) begin
                    state_d = next_phase(3'(state_q), nz);
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                end
                if (tmr_expired) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reload on every transition; non-timed targets get zero so the count is idle.
        if (state_d != state_q) begin
            tmr_load = 1'b1;
            case (state_d)
                ST_PRIME2: tmr_load_val = dur_sel[0] - CNT_W'(1);
                ST_PRIME3: tmr_load_val = dur_sel[1] - CNT_W'(1);
                ST_DOSE1:  tmr_load_val = dur_sel[2] - CNT_W'(1);
                ST_MIX:    tmr_load_val = dur_sel[3] - CNT_W'(1);
                ST_SAMPLE: tmr_load_val = dur_sel[4] - CNT_W'(1);
                ST_FLUSH:  tmr_load_val = dur_sel[5] - CNT_W'(1);
                default:   tmr_load_val = '0;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // exactly on the transition edge with no intermediate cycle.
    always_comb begin
        pump_en_d      = state_pump_en(state_d);
        valve_d        = state_valve_open(state_d);
        sample_valid_d = (state_d == ST_SAMPLE);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_FIN) && !abort_flag_d;
        aborted_d      = (state_d == ST_FIN) && abort_flag_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            abort_flag_q   <= 1'b0;
            dur_q          <= '0;
            pump_en_q      <= '0;
            valve_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            abort_flag_q   <= abort_flag_d;
            dur_q          <= dur_d;
            pump_en_q      <= pump_en_d;
            valve_q        <= valve_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

    assign pump_en        = pump_en_q;
    assign valve_out_open = valve_q;
    assign sample_valid   = sample_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign phase          = state_q;

endmodule

// File: tb/tb_smart_toilet_seq_ctrl.sv
// tb/tb_smart_toilet_seq_ctrl.sv - directed self-checking bench for smart_toilet_seq_ctrl
module tb_smart_toilet_seq_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] t_prime2, t_prime3, t_dose1, t_mix, t_sample, t_flush;
    logic [2:0]       pump_en;
    logic             valve_out_open;
    logic             sample_valid;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [2:0]       phase;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ph [0:63];
    int exp_len;
    bit exp_ab;

    always #5 clk = ~clk;

    smart_toilet_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .t_prime2       (t_prime2),
        .t_prime3       (t_prime3),
        .t_dose1        (t_dose1),
        .t_mix          (t_mix),
        .t_sample       (t_sample),
        .t_flush        (t_flush),
        .pump_en        (pump_en),
        .valve_out_open (valve_out_open),
        .sample_valid   (sample_valid),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .phase          (phase)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_exp(input bit ab);
        for (int i = 0; i < 64; i++) exp_ph[i] = 0;
        exp_len = 0;
        exp_ab  = ab;
    endtask

    task automatic add_seg(input int ph, input int len);
        repeat (len) begin
            exp_len++;
            exp_ph[exp_len] = ph;
        end
    endtask

    task automatic set_durs(input int p2, input int p3, input int d1,
                            input int mx, input int sm, input int fl);
        t_prime2 = CNT_W'(p2);
        t_prime3 = CNT_W'(p3);
        t_dose1  = CNT_W'(d1);
        t_mix    = CNT_W'(mx);
        t_sample = CNT_W'(sm);
        t_flush  = CNT_W'(fl);
    endtask

    task automatic nominal_segs();
        add_seg(1, 3); add_seg(2, 4); add_seg(3, 2); add_seg(4, 5);
        add_seg(5, 2); add_seg(6, 3); add_seg(7, 1);
    endtask

    task automatic check_cycle(input string name, input int c);
        int ph;
        int e_pump;
        ph = exp_ph[c];
        case (ph)
            1:       e_pump = 2;
            2:       e_pump = 4;
            3:       e_pump = 1;
            6:       e_pump = 7;
            default: e_pump = 0;
        endcase
        check_eq($sformatf("%s c%0d pump_en", name, c), int'(pump_en), e_pump);
        check_eq($sformatf("%s c%0d valve", name, c), int'(valve_out_open), int'(ph == 5 || ph == 6));
        check_eq($sformatf("%s c%0d sample_valid", name, c), int'(sample_valid), int'(ph == 5));
        check_eq($sformatf("%s c%0d busy", name, c), int'(busy), int'(ph != 0));
        check_eq($sformatf("%s c%0d done", name, c), int'(done), int'(ph == 7 && !exp_ab));
        check_eq($sformatf("%s c%0d aborted", name, c), int'(aborted), int'(ph == 7 && exp_ab));
        check_eq($sformatf("%s c%0d phase", name, c), int'(phase), ph);
    endtask

    // Start is sampled at edge 0; cycle c is the interval after edge c-1.
    // Mid-run actions set in cycle c are sampled at edge c.
    task automatic run(input string name, input int ncyc, input int abort_cyc,
                       input int poke_cyc, input int rst_cyc);
        start = 1'b1;
        abort = (abort_cyc == 0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            check_cycle(name, c);
            abort = (c == abort_cyc);
            start = (c == poke_cyc);
            rst_n = (c != rst_cyc);
            if (c == poke_cyc) set_durs(1, 1, 1, 1, 1, 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_durs(3, 4, 2, 5, 2, 3);
        repeat (3) @(posedge clk);
        #1;
        clear_exp(1'b0);
        check_cycle("reset", 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        clear_exp(1'b0); nominal_segs();
        run("nominal", 22, -1, -1, -1);

        set_durs(3, 0, 2, 0, 2, 3);
        clear_exp(1'b0);
        add_seg(1, 3); add_seg(3, 2); add_seg(5, 2); add_seg(6, 3); add_seg(7, 1);
        run("zero_skip", 13, -1, -1, -1);

        set_durs(0, 0, 0, 0, 0, 0);
        clear_exp(1'b0); add_seg(7, 1);
        run("all_zero", 3, -1, -1, -1);

        set_durs(3, 4, 2, 5, 2, 3);
        clear_exp(1'b1);
        add_seg(1, 3); add_seg(2, 2); add_seg(6, 3); add_seg(7, 1);
        run("abort_prime3", 11, 5, -1, -1);

        set_durs(3, 4, 2, 5, 2, 3);
        clear_exp(1'b0); nominal_segs();
        run("restart_ignored", 22, -1, 6, -1);

        set_durs(3, 4, 2, 5, 2, 3);
        clear_exp(1'b1); nominal_segs();
        run("abort_flush", 22, 18, -1, -1);

        set_durs(3, 4, 2, 5, 2, 3);
        clear_exp(1'b0); nominal_segs();
        run("start_abort_idle", 22, 0, -1, -1);

        set_durs(3, 4, 2, 5, 2, 3);
        clear_exp(1'b0); nominal_segs();
        run("abort_fin", 22, 20, -1, -1);

        set_durs(3, 4, 2, 5, 2, 3);
        clear_exp(1'b0);
        add_seg(1, 3); add_seg(2, 4); add_seg(3, 2);
        run("reset_mid", 12, -1, -1, 9);

        clear_exp(1'b0); nominal_segs();
        run("after_reset", 22, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
